icache_dm: RTL and testbench

Parametrised direct-mapped instruction cache between the IF stage and the memory controller. It holds one 32-bit instruction per line, answers hits combinationally in the request cycle, and on a miss runs a single outstanding fetch to the memory controller. It installs the returned word and forwards it to IF. It also supports a whole-cache flush for self-modifying code and `fence.i`.

---
 rtl/icache_dm.sv | 150 +++++++++++++++
 tb/tb_icache_dm.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_dm.sv
// icache_dm: direct-mapped instruction cache, one INST_W word per line.
// Hits are answered combinationally in the request cycle. A miss issues a
// single outstanding fetch, installs the returned word and forwards it to IF
// when IF is still asking for that word. A flush pulse invalidates every line.
//
// Ports:
//   clk, rst             clock and asynchronous active-high reset
//   if_req, if_addr      fetch request from IF (level, held until if_ready)
//   if_ready, if_inst    instruction returned to IF (if_inst is 0 when not ready)
//   mem_req, mem_addr    registered fetch request to the memory controller
//   mem_valid, mem_data  one-cycle data return from the memory controller
//   flush                one-cycle pulse invalidating all lines
module icache_dm #(
  parameter int ADDR_W  = 32,
  parameter int INDEX_W = 8,
  parameter int INST_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [INST_W-1:0] if_inst,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_valid,
  input  logic [INST_W-1:0] mem_data,
  input  logic              flush
);

  localparam int TAG_W = ADDR_W - INDEX_W - 2;
  localparam int LINES = 1 << INDEX_W;

  typedef enum logic {
    IDLE = 1'b0,
    MISS = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [LINES-1:0]    valid_q, valid_d;
  logic                mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                flush_pend_q, flush_pend_d;

  logic [TAG_W-1:0]    tag_q  [LINES];
  logic [INST_W-1:0]   data_q [LINES];

  logic [INDEX_W-1:0]  req_index_s;
  logic [TAG_W-1:0]    req_tag_s;
  logic [INDEX_W-1:0]  miss_index_s;
  logic [TAG_W-1:0]    miss_tag_s;
  logic                hit_s;
  logic                fwd_s;
  logic                fill_s;
  logic                unused_s;

  assign req_index_s  = if_addr[INDEX_W+1:2];
  assign req_tag_s    = if_addr[ADDR_W-1:INDEX_W+2];
  // The latched miss address already carries the line index and tag.
  assign miss_index_s = mem_addr_q[INDEX_W+1:2];
  assign miss_tag_s   = mem_addr_q[ADDR_W-1:INDEX_W+2];
  assign unused_s     = ^if_addr[1:0];

  assign hit_s  = (state_q == IDLE) && if_req && valid_q[req_index_s] &&
                  (tag_q[req_index_s] == req_tag_s);
  assign fill_s = (state_q == MISS) && mem_valid;
  // Forward only when IF still wants exactly the word being returned.
  assign fwd_s  = fill_s && if_req &&
                  (if_addr[ADDR_W-1:2] == mem_addr_q[ADDR_W-1:2]);

  assign if_ready = !rst && (hit_s || fwd_s);
  assign if_inst  = !if_ready ? {INST_W{1'b0}} :
                    hit_s     ? data_q[req_index_s] : mem_data;
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;

  // Next-state, fetch request and valid-bit update logic.
  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    flush_pend_d = flush_pend_q;
    case (state_q)
      IDLE: begin
        if (if_req && !hit_s) begin
          state_d    = MISS;
          mem_req_d  = 1'b1;
          mem_addr_d = {if_addr[ADDR_W-1:2], 2'b00};
        end else begin
          state_d    = IDLE;
        end
      end
      MISS: begin
        if (mem_valid) begin
          state_d      = IDLE;
          mem_req_d    = 1'b0;
          flush_pend_d = 1'b0;
        end else if (flush) begin
          // Data already in flight predates the flush; do not trust it.
          flush_pend_d = 1'b1;
        end else begin
          flush_pend_d = flush_pend_q;
        end
      end
      default: begin
        state_d      = IDLE;
        mem_req_d    = 1'b0;
        flush_pend_d = 1'b0;
      end
    endcase
    if (flush) begin
      valid_d = {LINES{1'b0}};
    end else begin
      valid_d = valid_q;
    end
    // A flush this cycle or pending from earlier in the miss leaves the fill invalid.
    if (fill_s) begin
      valid_d[miss_index_s] = !(flush || flush_pend_q);
    end else begin
      valid_d = valid_d;
    end
  end

  // Control state registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      valid_q      <= {LINES{1'b0}};
      mem_req_q    <= 1'b0;
      mem_addr_q   <= {ADDR_W{1'b0}};
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  // Tag and data arrays; contents are qualified by the valid bits, so no reset.
  always_ff @(posedge clk) begin
    if (fill_s) begin
      tag_q[miss_index_s]  <= miss_tag_s;
      data_q[miss_index_s] <= mem_data;
    end
  end

endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm: two instances (32-bit/256-line and
// 16-bit/16-line) driven one at a time against a word-level reference model.
module tb_icache_dm;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        mem_valid;
  logic [31:0] mem_data;
  logic        flush;
  int          sel;

  logic        req0, req1, mv0, mv1, fl0, fl1;
  logic        r0, r1, mq0, mq1;
  logic [31:0] i0, i1, ma0;
  logic [15:0] ma1;
  logic        o_ready, o_mreq;
  logic [31:0] o_inst, o_maddr;

  assign req0 = if_req & (sel == 0);
  assign req1 = if_req & (sel == 1);
  assign mv0  = mem_valid & (sel == 0);
  assign mv1  = mem_valid & (sel == 1);
  assign fl0  = flush & (sel == 0);
  assign fl1  = flush & (sel == 1);

  assign o_ready = (sel == 1) ? r1 : r0;
  assign o_inst  = (sel == 1) ? i1 : i0;
  assign o_mreq  = (sel == 1) ? mq1 : mq0;
  assign o_maddr = (sel == 1) ? {16'h0000, ma1} : ma0;

  icache_dm #(.ADDR_W(32), .INDEX_W(8), .INST_W(32)) dut0 (
    .clk(clk), .rst(rst), .if_req(req0), .if_addr(if_addr),
    .if_ready(r0), .if_inst(i0), .mem_req(mq0), .mem_addr(ma0),
    .mem_valid(mv0), .mem_data(mem_data), .flush(fl0));

  icache_dm #(.ADDR_W(16), .INDEX_W(4), .INST_W(32)) dut1 (
    .clk(clk), .rst(rst), .if_req(req1), .if_addr(if_addr[15:0]),
    .if_ready(r1), .if_inst(i1), .mem_req(mq1), .mem_addr(ma1),
    .mem_valid(mv1), .mem_data(mem_data), .flush(fl1));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: per-line word address of the cached word, data, valid.
  bit          m_v [256];
  logic [31:0] m_a [256];
  logic [31:0] m_d [256];
  bit          m_miss, m_pend;
  logic [31:0] m_addr;
  int          m_cnt;
  int          cur_lat;
  int          iw;
  logic [31:0] amask;
  logic        last_ready, last_mreq;
  logic [31:0] last_inst, last_maddr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) & ((32'h1 << iw) - 32'h1));
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hC0DE0000;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 256; k++) m_v[k] = 1'b0;
    m_miss = 1'b0;
    m_pend = 1'b0;
    m_cnt  = 0;
  endtask

  // One clock cycle: drive, check at the falling edge, advance the model.
  task automatic step(input bit req, input logic [31:0] addr, input bit fl, input bit stray);
    logic [31:0] w;
    logic [31:0] e_inst;
    bit h, f, mvl;
    int ix;
    w       = addr & amask & 32'hFFFF_FFFC;
    if_req  = req;
    if_addr = addr & amask;
    flush   = fl;
    if (m_miss && m_cnt == 0) begin
      mem_valid = 1'b1;
      mem_data  = mem_word(m_addr);
    end else if (!m_miss && stray) begin
      mem_valid = 1'b1;
      mem_data  = $urandom;
    end else begin
      mem_valid = 1'b0;
      mem_data  = $urandom;
    end
    mvl = mem_valid;
    #4;
    ix = idx_of(w);
    h  = !m_miss && req && m_v[ix] && (m_a[ix] == w);
    f  = m_miss && mvl && req && (w == m_addr);
    e_inst = h ? m_d[ix] : (f ? mem_data : 32'h0);
    last_ready = o_ready;
    last_inst  = o_inst;
    last_mreq  = o_mreq;
    last_maddr = o_maddr;
    check("if_ready", {31'h0, o_ready}, {31'h0, (h || f)});
    check("if_inst", o_inst, e_inst);
    check("mem_req", {31'h0, o_mreq}, {31'h0, m_miss});
    if (m_miss) check("mem_addr", o_maddr, m_addr);
    if (fl) for (int k = 0; k < 256; k++) m_v[k] = 1'b0;
    if (m_miss && mvl) begin
      ix = idx_of(m_addr);
      m_a[ix] = m_addr;
      m_d[ix] = mem_data;
      m_v[ix] = !(fl || m_pend);
      m_pend  = 1'b0;
      m_miss  = 1'b0;
    end else if (m_miss) begin
      if (fl) m_pend = 1'b1;
      m_cnt--;
    end else if (req && !h) begin
      m_miss = 1'b1;
      m_addr = w;
      m_cnt  = cur_lat;
    end
    @(posedge clk);
    #1;
  endtask

  // Keep requesting one address until it is returned, within a cycle bound.
  task automatic fetch(input logic [31:0] addr);
    for (int k = 0; k < 20; k++) begin
      step(1'b1, addr, 1'b0, 1'b0);
      if (last_ready) break;
    end
    check("fetch_done", {31'h0, last_ready}, 32'h1);
  endtask

  // Asynchronous reset applied mid-cycle; outputs must drop immediately.
  task automatic do_reset();
    if_req    = 1'b1;
    mem_valid = 1'b0;
    flush     = 1'b0;
    rst       = 1'b1;
    #1;
    check("rst_mem_req", {31'h0, o_mreq}, 32'h0);
    check("rst_if_ready", {31'h0, o_ready}, 32'h0);
    check("rst_if_inst", o_inst, 32'h0);
    check("rst_mem_addr", o_maddr, 32'h0);
    mem_valid = 1'b1;
    @(posedge clk);
    #1;
    mem_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic basic_latency();
    cur_lat = 3;
    step(1'b1, 32'h100, 1'b0, 1'b0);
    check("c0_ready", {31'h0, last_ready}, 32'h0);
    step(1'b1, 32'h100, 1'b0, 1'b0);
    check("c1_mem_req", {31'h0, last_mreq}, 32'h1);
    check("c1_mem_addr", last_maddr, 32'h100);
    step(1'b1, 32'h100, 1'b0, 1'b0);
    step(1'b1, 32'h100, 1'b0, 1'b0);
    step(1'b1, 32'h100, 1'b0, 1'b0);
    check("c4_ready", {31'h0, last_ready}, 32'h1);
    check("c4_inst", last_inst, mem_word(32'h100));
    step(1'b1, 32'h100, 1'b0, 1'b0);
    check("c5_hit", {31'h0, last_ready}, 32'h1);
    check("c5_mem_req", {31'h0, last_mreq}, 32'h0);
  endtask

  task automatic random_run(input int cycles);
    bit          req;
    logic [31:0] addr;
    req  = 1'b1;
    addr = 32'h0;
    for (int c = 0; c < cycles; c++) begin
      if (!m_miss) cur_lat = $urandom_range(0, 4);
      step(req, addr, ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0));
      if (last_ready || !req || $urandom_range(0, 9) == 0) begin
        req  = ($urandom_range(0, 7) != 0);
        addr = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 15) << 2) |
               $urandom_range(0, 3);
      end
    end
  endtask

  initial begin
    sel       = 0;
    iw        = 8;
    amask     = 32'hFFFF_FFFF;
    rst       = 1'b1;
    if_req    = 1'b0;
    if_addr   = 32'h0;
    mem_valid = 1'b0;
    mem_data  = 32'h0;
    flush     = 1'b0;
    cur_lat   = 3;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    basic_latency();

    // Aliasing on the same index.
    cur_lat = 2;
    fetch(32'h500);
    step(1'b1, 32'h100, 1'b0, 1'b0);
    check("alias_miss", {31'h0, last_ready}, 32'h0);
    fetch(32'h100);

    // Redirect during a miss: 0x200 still installs, 0x204 is not forwarded.
    step(1'b1, 32'h200, 1'b0, 1'b0);
    for (int k = 0; k < 20 && m_miss; k++) step(1'b1, 32'h204, 1'b0, 1'b0);
    step(1'b1, 32'h200, 1'b0, 1'b0);
    check("redirect_hit", {31'h0, last_ready}, 32'h1);
    step(1'b1, 32'h204, 1'b0, 1'b0);
    check("redirect_miss", {31'h0, last_ready}, 32'h0);
    fetch(32'h204);

    // Flush in IDLE, then flush coinciding with the data return.
    fetch(32'h300);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 32'h300, 1'b0, 1'b0);
    check("flush_miss", {31'h0, last_ready}, 32'h0);
    fetch(32'h300);
    step(1'b1, 32'h400, 1'b0, 1'b0);
    for (int k = 0; k < 20 && !(m_miss && m_cnt == 0); k++) step(1'b1, 32'h400, 1'b0, 1'b0);
    step(1'b1, 32'h400, 1'b1, 1'b0);
    check("flush_fwd", {31'h0, last_ready}, 32'h1);
    step(1'b1, 32'h400, 1'b0, 1'b0);
    check("flush_fill_inv", {31'h0, last_ready}, 32'h0);
    fetch(32'h400);

    // Reset during a miss; a stray return afterwards is ignored.
    cur_lat = 4;
    step(1'b1, 32'h600, 1'b0, 1'b0);
    step(1'b1, 32'h600, 1'b0, 1'b0);
    do_reset();
    step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b1, 32'h300, 1'b0, 1'b0);
    check("post_rst_miss", {31'h0, last_ready}, 32'h0);
    fetch(32'h300);

    random_run(1500);

    // Smaller configuration: 16-bit addresses, index from bits [5:2].
    sel   = 1;
    iw    = 4;
    amask = 32'h0000_FFFF;
    do_reset();
    basic_latency();
    cur_lat = 1;
    fetch(32'h140);
    step(1'b1, 32'h100, 1'b0, 1'b0);
    check("alias16_miss", {31'h0, last_ready}, 32'h0);
    fetch(32'h100);
    random_run(1500);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
